// File: rtl/hsv_to_rgb_pipe.sv
// hsv_to_rgb_pipe: streaming HSV -> RGB converter, integer arithmetic, no dividers.
// Latency: 3 register stages, so a pixel accepted on one edge is on out_rgb after the 2nd following edge.
// Backpressure: all stages advance together when (!out_valid | out_ready); in_ready is that term, combinationally.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_hsv{H,S,V}/in_user,
//        out_valid/out_ready/out_rgb{R,G,B}/out_user.
// Optional: define HSV_BYPASS_EN to add in_bypass, which passes in_hsv straight to out_rgb.
module hsv_to_rgb_pipe #(
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_hsv,
  input  logic [USER_W-1:0] in_user,
`ifdef HSV_BYPASS_EN
  input  logic              in_bypass,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_rgb,
  output logic [USER_W-1:0] out_user
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: sector split ----------------
  // H in 0..255 times 6 gives 0..1530; the top 3 bits are the 60-degree
  // sector (never above 5) and the low byte is the position inside it.
  logic [10:0] hs6;
  assign hs6 = {3'd0, in_hsv[23:16]} * 11'd6;

  logic              s1_vld;
  logic [7:0]        s1_s, s1_v, s1_f;
  logic [2:0]        s1_region;
  logic              s1_gray;
  logic [USER_W-1:0] s1_user;

  // ---------------- stage 2: p/q/t products ----------------
  // 255-x is written as ~x on 8-bit values. Every product is 8x8 -> 16 bits,
  // so keeping the upper byte never overflows.
  logic [7:0] p_c, q_c, t_c;
  assign p_c = 8'(({8'd0, s1_v} * {8'd0, ~s1_s}) >> 8);
  assign q_c = 8'(({8'd0, s1_v} *
                   {8'd0, ~(8'(({8'd0, s1_s} * {8'd0, s1_f}) >> 8))}) >> 8);
  assign t_c = 8'(({8'd0, s1_v} *
                   {8'd0, ~(8'(({8'd0, s1_s} * {8'd0, ~s1_f}) >> 8))}) >> 8);

  logic              s2_vld;
  logic [7:0]        s2_v, s2_p, s2_q, s2_t;
  logic [2:0]        s2_region;
  logic              s2_gray;
  logic [USER_W-1:0] s2_user;

`ifdef HSV_BYPASS_EN
  // Raw pixel travels alongside so bypass keeps the same latency.
  logic        s1_byp, s2_byp;
  logic [23:0] s1_raw, s2_raw;
`endif

  // ---------------- stage 3: sector select ----------------
  logic [23:0] rgb_c;
  always_comb begin
    rgb_c = {s2_v, s2_v, s2_v};
    if (!s2_gray) begin
      case (s2_region)
        3'd0:    rgb_c = {s2_v, s2_t, s2_p};
        3'd1:    rgb_c = {s2_q, s2_v, s2_p};
        3'd2:    rgb_c = {s2_p, s2_v, s2_t};
        3'd3:    rgb_c = {s2_p, s2_q, s2_v};
        3'd4:    rgb_c = {s2_t, s2_p, s2_v};
        3'd5:    rgb_c = {s2_v, s2_p, s2_q};
        default: rgb_c = {s2_v, s2_v, s2_v};
      endcase
    end
`ifdef HSV_BYPASS_EN
    if (s2_byp) rgb_c = s2_raw;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld    <= 1'b0;
      s1_s      <= '0;
      s1_v      <= '0;
      s1_f      <= '0;
      s1_region <= '0;
      s1_gray   <= 1'b0;
      s1_user   <= '0;
      s2_vld    <= 1'b0;
      s2_v      <= '0;
      s2_p      <= '0;
      s2_q      <= '0;
      s2_t      <= '0;
      s2_region <= '0;
      s2_gray   <= 1'b0;
      s2_user   <= '0;
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_user  <= '0;
`ifdef HSV_BYPASS_EN
      s1_byp    <= 1'b0;
      s1_raw    <= '0;
      s2_byp    <= 1'b0;
      s2_raw    <= '0;
`endif
    end else if (adv) begin
      // Bubbles shift through like pixels; nothing is compressed.
      s1_vld    <= in_valid;
      s1_s      <= in_hsv[15:8];
      s1_v      <= in_hsv[7:0];
      s1_f      <= hs6[7:0];
      s1_region <= hs6[10:8];
      s1_gray   <= (in_hsv[15:8] == 8'd0);
      s1_user   <= in_user;
      s2_vld    <= s1_vld;
      s2_v      <= s1_v;
      s2_p      <= p_c;
      s2_q      <= q_c;
      s2_t      <= t_c;
      s2_region <= s1_region;
      s2_gray   <= s1_gray;
      s2_user   <= s1_user;
      out_valid <= s2_vld;
      out_rgb   <= rgb_c;
      out_user  <= s2_user;
`ifdef HSV_BYPASS_EN
      s1_byp    <= in_bypass;
      s1_raw    <= in_hsv;
      s2_byp    <= s1_byp;
      s2_raw    <= s1_raw;
`endif
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// tb_hsv_to_rgb_pipe: directed-vector bench for hsv_to_rgb_pipe.
// Expected colours are hand-computed from the integer HSV formulas.
// Define HSV_BYPASS_EN to also exercise the bypass port.
module tb_hsv_to_rgb_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_hsv;
  logic [1:0]  in_user;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic [1:0]  out_user;
`ifdef HSV_BYPASS_EN
  logic        in_bypass;
`endif

  int vectors = 0;
  int errors  = 0;

  // Hand-computed conversions (H*6 -> region/f, then p/q/t with >>8).
  localparam logic [23:0] CONV_HSV [8] = '{
    24'h00FFFF, 24'h56FFFF, 24'hABFFFF, 24'h2BFFFF,
    24'h80FFFF, 24'hFFFFFF, 24'h0080C8, 24'h64C800};
  localparam logic [23:0] CONV_RGB [8] = '{
    24'hFF0000, 24'h00FF04, 24'h0200FF, 24'hFDFF00,
    24'h00FEFF, 24'hFF0005, 24'hC86463, 24'h000000};
  localparam logic [23:0] GRAY_HSV [3] = '{24'h000080, 24'h640080, 24'hFF0080};

  hsv_to_rgb_pipe #(.USER_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hsv    (in_hsv),
    .in_user   (in_user),
`ifdef HSV_BYPASS_EN
    .in_bypass (in_bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rgb   (out_rgb),
    .out_user  (out_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_hsv = '0; in_user = '0; out_ready = 1'b1;
`ifdef HSV_BYPASS_EN
    in_bypass = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_rgb !== 24'h0) begin errors++; $display("FAIL reset_out_rgb: got %h want 000000", out_rgb); end
    vectors++; if (out_user !== 2'b0) begin errors++; $display("FAIL reset_out_user: got %b want 00", out_user); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
  endtask

  // Single pixel per pass: checks latency, one-cycle valid pulse, colour and tag.
  task automatic test_convert;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_hsv = CONV_HSV[i]; in_user = 2'(i); out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL conv%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv%0d_early1: out_valid %b want 0", i, out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv%0d_early2: out_valid %b want 0", i, out_valid); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv%0d_valid: out_valid %b want 1", i, out_valid); end
      vectors++; if (out_rgb !== CONV_RGB[i]) begin errors++; $display("FAIL conv%0d_rgb: got %h want %h", i, out_rgb, CONV_RGB[i]); end
      vectors++; if (out_user !== 2'(i)) begin errors++; $display("FAIL conv%0d_user: got %b want %b", i, out_user, 2'(i)); end
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv%0d_pulse: out_valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_gray;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_hsv = GRAY_HSV[i]; in_user = 2'd3; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gray%0d_valid: out_valid %b want 1", i, out_valid); end
      vectors++; if (out_rgb !== 24'h808080) begin errors++; $display("FAIL gray%0d_rgb: got %h want 808080", i, out_rgb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    logic acc, take;
    while (got < 8 && cyc < 200) begin
      out_ready = (cyc >= 2 && cyc < 12) ? 1'b0 : 1'b1;
      in_valid  = (sent < 8);
      in_hsv    = (sent < 8) ? CONV_HSV[sent] : 24'h0;
      in_user   = 2'(sent);
      #1;
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (cyc == 3 || cyc == 11) begin
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
        vectors++; if (sent !== 3) begin errors++; $display("FAIL b2b_in_flight cyc%0d: accepted %0d want 3", cyc, sent); end
      end
      if (take) begin
        vectors++;
        if (got >= 8) begin
          errors++; $display("FAIL b2b_extra: unexpected pixel %h", out_rgb);
        end else if (out_rgb !== CONV_RGB[got] || out_user !== 2'(got)) begin
          errors++;
          $display("FAIL b2b_pix%0d: got rgb %h user %b want rgb %h user %b",
                   got, out_rgb, out_user, CONV_RGB[got], 2'(got));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d pixels want 8", got); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: out_valid %b want 0 (%h)", out_valid, out_rgb); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream;
    int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_hsv = 24'h000011 * 24'(i + 1); in_user = 2'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full: out_valid %b want 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    vectors++; if (out_rgb !== 24'h0) begin errors++; $display("FAIL rst_mid_rgb: got %h want 000000", out_rgb); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_hsv = 24'h000077; in_user = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) begin
        seen++;
        vectors++; if (out_rgb !== 24'h777777) begin errors++; $display("FAIL rst_mid_new: got %h want 777777", out_rgb); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (seen !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d pixels want 1", seen); end
  endtask

`ifdef HSV_BYPASS_EN
  task automatic test_bypass;
    out_ready = 1'b1;
    in_valid = 1'b1; in_bypass = 1'b1; in_hsv = 24'h123456; in_user = 2'd1;
    @(posedge clk); #1;
    in_bypass = 1'b0; in_hsv = 24'h00FFFF; in_user = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || out_rgb !== 24'h123456) begin errors++; $display("FAIL bypass_raw: valid %b rgb %h want 1 123456", out_valid, out_rgb); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || out_rgb !== 24'hFF0000) begin errors++; $display("FAIL bypass_next: valid %b rgb %h want 1 FF0000", out_valid, out_rgb); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_gray();
    test_back_to_back();
    test_reset_midstream();
`ifdef HSV_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
